// File: rtl/noc_inj_pkg.sv
// Shared types for the NoC packet injector: flit types, FSM states,
// head-flit field layout and the node-id to mesh-coordinate helper.
package noc_inj_pkg;

    typedef enum logic [1:0] {
        FLIT_IDLE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_PAYLOAD
    } state_t;

    localparam int HEAD_COORD_W = 4;
    localparam int HEAD_SRC_W   = 4;
    localparam int HEAD_DX_LSB  = 0;
    localparam int HEAD_DY_LSB  = 4;
    localparam int HEAD_SRC_LSB = 8;
    localparam int HEAD_LEN_LSB = 12;

    typedef struct packed {
        logic [HEAD_COORD_W-1:0] y;
        logic [HEAD_COORD_W-1:0] x;
    } node_xy_t;

    // Row-major node id: id = y*cols + x.
    function automatic node_xy_t node_to_xy(input logic [3:0] id, input int cols);
        node_xy_t xy;
        xy.x = HEAD_COORD_W'(int'(id) % cols);
        xy.y = HEAD_COORD_W'(int'(id) / cols);
        return xy;
    endfunction

endpackage

// File: rtl/noc_inj_out_reg.sv
// Single-entry flit output register: holds a flit until the consumer takes it.
// A flit whose type field is 00 means the register is empty.
module noc_inj_out_reg
    import noc_inj_pkg::*;
#(
    parameter int FLIT_W = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              ready_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              valid_o,
    output logic              xfer_o
);

    logic [FLIT_W-1:0] flit_q, flit_d;

    assign valid_o = flit_type_t'(flit_q[FLIT_W-1 -: 2]) != FLIT_IDLE;
    assign xfer_o  = valid_o & ready_i;
    assign flit_o  = flit_q;

    // NOTE: default assigned first so every path drives flit_d and no latch is inferred.
    always_comb begin
        flit_d = flit_q;
        if (load_i) begin
            flit_d = flit_i;
        end else if (xfer_o) begin
            flit_d = '0;
        end
    end

    // NOTE: non-blocking for registered state so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_q <= '0;
        end else begin
            flit_q <= flit_d;
        end
    end

endmodule

// File: rtl/noc_packet_injector.sv
// Host-side packet injector: one request plus payload words -> head/body/tail flits.
// Define NOC_INJ_STATS_EN to add saturating packet/flit/stall counters.
module noc_packet_injector
    import noc_inj_pkg::*;
#(
    parameter int          X      = 3,
    parameter int          Y      = 3,
    parameter int          DATA_W = 32,
    parameter int          LEN_W  = 8,
    parameter logic [3:0]  SRC_ID = 4'd15,
    parameter int          FLIT_W = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [FLIT_W-1:0] flitOut,
    input  logic              networkReady,
    output logic              busy,
    output logic              err_drop
`ifdef NOC_INJ_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_flits,
    output logic [31:0]       stat_stall
`endif
);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                req_ready_q;
    logic                err_q, err_d;
    logic                load;
    logic [FLIT_W-1:0]   load_flit;
    logic                out_valid, xfer;
    flit_type_t          out_type;
    logic [DATA_W-1:0]   head_payload;
    node_xy_t            dest_xy;
    logic                req_acc, req_bad, word_acc;

    assign req_acc  = req_valid & req_ready_q;
    assign req_bad  = (int'(req_dest) >= X * Y) || (req_len == '0);
    assign out_type = flit_type_t'(flitOut[FLIT_W-1 -: 2]);
    assign dest_xy  = node_to_xy(req_dest, X);

    always_comb begin
        head_payload = '0;
        head_payload[HEAD_DX_LSB  +: HEAD_COORD_W] = dest_xy.x;
        head_payload[HEAD_DY_LSB  +: HEAD_COORD_W] = dest_xy.y;
        head_payload[HEAD_SRC_LSB +: HEAD_SRC_W]   = SRC_ID;
        head_payload[HEAD_LEN_LSB +: LEN_W]        = req_len;
    end

    // The head sits in the output register for the whole HEAD state, so the first
    // word can be pulled in on the head's transfer cycle with no bubble.
    assign data_ready = (state_q != ST_IDLE) && (rem_q != '0) && (!out_valid || networkReady);
    assign word_acc   = data_ready & data_valid;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_flit = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_acc) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_HEAD;
                        rem_d     = req_len;
                        load      = 1'b1;
                        load_flit = {FLIT_HEAD, head_payload};
                    end
                end
            end
            ST_HEAD: begin
                if (xfer) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (xfer && out_type == FLIT_TAIL) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (word_acc) begin
            load      = 1'b1;
            load_flit = {(rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY, data_in};
            rem_d     = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            req_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            req_ready_q <= (state_d == ST_IDLE);
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign err_drop  = err_q;
    assign busy      = (state_q != ST_IDLE);

    noc_inj_out_reg #(
        .FLIT_W (FLIT_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flit_i  (load_flit),
        .ready_i (networkReady),
        .flit_o  (flitOut),
        .valid_o (out_valid),
        .xfer_o  (xfer)
    );

`ifdef NOC_INJ_STATS_EN
    logic [31:0] pkts_q, flits_q, stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkts_q  <= '0;
            flits_q <= '0;
            stall_q <= '0;
        end else begin
            if (xfer && out_type == FLIT_TAIL && pkts_q != '1) pkts_q <= pkts_q + 32'd1;
            if (xfer && flits_q != '1) flits_q <= flits_q + 32'd1;
            if (out_valid && !networkReady && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_pkts  = pkts_q;
    assign stat_flits = flits_q;
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed self-checking bench for noc_packet_injector: normal packets, backpressure,
// single-word packets, rejected requests and reset mid-packet.
module tb_noc_packet_injector;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int FLIT_W = DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_dest;
    logic [LEN_W-1:0]  req_len;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data_in;
    logic [FLIT_W-1:0] flitOut;
    logic              networkReady;
    logic              busy;
    logic              err_drop;
`ifdef NOC_INJ_STATS_EN
    logic [31:0]       stat_pkts, stat_flits, stat_stall;
`endif

    int checks = 0;
    int passed = 0;

    noc_packet_injector dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dest     (req_dest),
        .req_len      (req_len),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_in      (data_in),
        .flitOut      (flitOut),
        .networkReady (networkReady),
        .busy         (busy),
        .err_drop     (err_drop)
`ifdef NOC_INJ_STATS_EN
        ,
        .stat_pkts    (stat_pkts),
        .stat_flits   (stat_flits),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FLIT_W-1:0] fl(input logic [1:0] t, input logic [DATA_W-1:0] d);
        return {t, d};
    endfunction

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_dest = '0; req_len = '0;
        data_valid = 1'b0; data_in = '0; networkReady = 1'b1;

        // Reset asserted between edges must clear outputs at once.
        #2 rst = 1'b1;
        #1;
        check("rst_flit",  flitOut,   '0);
        check("rst_rready", req_ready, 1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_err",   err_drop,  1'b0);
        check("rst_dready", data_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1 check("rdy_still_low", req_ready, 1'b0);
        tick();
        check("rdy_after_rst", req_ready, 1'b1);

        // dest=5 len=3: head dx=2 dy=1 src=15 len=3, body A, body B, tail C.
        req_valid = 1'b1; req_dest = 4'd5; req_len = 8'd3;
        tick();
        req_valid = 1'b0;
        check("p1_head", flitOut, fl(2'b01, 32'h0000_3F12));
        check("p1_rready", req_ready, 1'b0);
        check("p1_busy", busy, 1'b1);
        data_valid = 1'b1; data_in = 32'hAAAA_0001;
        #1 check("p1_dready", data_ready, 1'b1);
        tick();
        check("p1_bodyA", flitOut, fl(2'b10, 32'hAAAA_0001));
        data_in = 32'hBBBB_0002;
        tick();
        check("p1_bodyB", flitOut, fl(2'b10, 32'hBBBB_0002));
        data_in = 32'hCCCC_0003;
        tick();
        check("p1_tailC", flitOut, fl(2'b11, 32'hCCCC_0003));
        data_valid = 1'b0;
        #1 check("p1_dready_done", data_ready, 1'b0);
        check("p1_rready_tail", req_ready, 1'b0);
        tick();
        check("p1_idle_flit", flitOut, '0);
        check("p1_rready_after", req_ready, 1'b1);
        check("p1_busy_after", busy, 1'b0);

        // Same packet with two stall cycles while body A is presented.
        req_valid = 1'b1; req_dest = 4'd5; req_len = 8'd3;
        tick();
        req_valid = 1'b0;
        check("p2_head", flitOut, fl(2'b01, 32'h0000_3F12));
        data_valid = 1'b1; data_in = 32'hAAAA_0001;
        tick();
        check("p2_bodyA", flitOut, fl(2'b10, 32'hAAAA_0001));
        networkReady = 1'b0; data_in = 32'hBBBB_0002;
        #1 check("p2_dready_stall", data_ready, 1'b0);
        tick();
        check("p2_hold1", flitOut, fl(2'b10, 32'hAAAA_0001));
        tick();
        check("p2_hold2", flitOut, fl(2'b10, 32'hAAAA_0001));
        networkReady = 1'b1;
        #1 check("p2_dready_resume", data_ready, 1'b1);
        tick();
        check("p2_bodyB", flitOut, fl(2'b10, 32'hBBBB_0002));
        data_in = 32'hCCCC_0003;
        tick();
        check("p2_tailC", flitOut, fl(2'b11, 32'hCCCC_0003));
        data_valid = 1'b0;
        tick();
        check("p2_idle_flit", flitOut, '0);
        check("p2_rready_after", req_ready, 1'b1);

        // len=1 dest=0: head then tail directly.
        req_valid = 1'b1; req_dest = 4'd0; req_len = 8'd1;
        tick();
        req_valid = 1'b0;
        check("p3_head", flitOut, fl(2'b01, 32'h0000_1F00));
        data_valid = 1'b1; data_in = 32'hDDDD_0004;
        tick();
        check("p3_tail", flitOut, fl(2'b11, 32'hDDDD_0004));
        data_valid = 1'b0;
        tick();
        check("p3_idle_flit", flitOut, '0);
        check("p3_rready_after", req_ready, 1'b1);

        // Out-of-range destination and zero length are dropped.
        req_valid = 1'b1; req_dest = 4'd9; req_len = 8'd2;
        tick();
        req_valid = 1'b0;
        check("e1_err", err_drop, 1'b1);
        check("e1_flit", flitOut, '0);
        check("e1_rready", req_ready, 1'b1);
        tick();
        check("e1_err_clear", err_drop, 1'b0);
        check("e1_busy", busy, 1'b0);
        req_valid = 1'b1; req_dest = 4'd3; req_len = 8'd0;
        tick();
        req_valid = 1'b0;
        check("e2_err", err_drop, 1'b1);
        check("e2_flit", flitOut, '0);
        check("e2_rready", req_ready, 1'b1);
        tick();
        check("e2_err_clear", err_drop, 1'b0);
        check("e2_flit_after", flitOut, '0);

        // Reset after the head of a len=4 packet has been transferred.
        req_valid = 1'b1; req_dest = 4'd4; req_len = 8'd4;
        tick();
        req_valid = 1'b0;
        check("r_head", flitOut, fl(2'b01, 32'h0000_4F11));
        data_valid = 1'b1; data_in = 32'hEEEE_0005;
        tick();
        check("r_bodyE", flitOut, fl(2'b10, 32'hEEEE_0005));
        rst = 1'b1;
        #1;
        check("r_flit", flitOut, '0);
        check("r_busy", busy, 1'b0);
        check("r_dready", data_ready, 1'b0);
        data_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("r_rready", req_ready, 1'b1);
        req_valid = 1'b1; req_dest = 4'd8; req_len = 8'd2;
        tick();
        req_valid = 1'b0;
        check("r2_head", flitOut, fl(2'b01, 32'h0000_2F22));
        data_valid = 1'b1; data_in = 32'hF0F0_0006;
        tick();
        check("r2_bodyF", flitOut, fl(2'b10, 32'hF0F0_0006));
        data_in = 32'h0F0F_0007;
        tick();
        check("r2_tailG", flitOut, fl(2'b11, 32'h0F0F_0007));
        data_valid = 1'b0;
        tick();
        check("r2_idle_flit", flitOut, '0);
        check("r2_rready", req_ready, 1'b1);
`ifdef NOC_INJ_STATS_EN
        check("stat_pkts", stat_pkts, 32'd1);
        check("stat_flits", stat_flits, 32'd3);
        check("stat_stall", stat_stall, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Host-side transmitter that turns one request (destination node, length, payload words) into a flit packet for a mesh router local port.
- Drives the same flit/ready interface a core's collector receives on; used by testbenches and the debug host to load programs or data into any core's RAM across the NoC.
- Head flit carries routing fields; payload words follow as body flits; the last payload word is the tail flit.

Parameters:
- X, 3, mesh columns
- Y, 3, mesh rows
- DATA_W, 32, payload word width
- LEN_W, 8, packet length field width (words)
- SRC_ID, 15, source id placed in head flit (4 bits)
- FLIT_W, DATA_W+2, flit width: {type[1:0], payload[DATA_W-1:0]}

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when valid&ready
- req_dest  in  4  destination node id, row-major (id = y*X + x)
- req_len  in  LEN_W  payload word count
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word accepted when valid&ready
- data_in  in  DATA_W  payload word
- flitOut  out  FLIT_W  flit to router; type 00 means no flit
- networkReady  in  1  router accepts flitOut this cycle
- busy  out  1  packet in progress
- err_drop  out  1  one-cycle pulse: request rejected

Behaviour:
- Single clock domain. Reset (rst high, asynchronous): state IDLE, flitOut=0, req_ready=0, data_ready=0, busy=0, err_drop=0, counters cleared.
- Flit types: 00 idle, 01 head, 10 body, 11 tail.
- Head payload layout: [3:0] dest_x = req_dest % X; [7:4] dest_y = req_dest / X; [11:8] SRC_ID; [19:12] len; upper bits zero.
- A flit transfers on a cycle where flitOut type != 00 and networkReady=1.
- flitOut is held stable until transferred. It changes only on transfer or reset.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch dest and len.
  - If req_dest >= X*Y or req_len == 0: pulse err_drop next cycle and stay in IDLE; no flit is emitted.
  - Otherwise go to HEAD; the head flit appears on flitOut the cycle after acceptance.
- State HEAD:
  - req_ready=0, busy=1.
  - On head transfer, go to PAYLOAD with remaining = len.
- State PAYLOAD:
  - data_ready=1 when the output register is empty or transferring this cycle.
  - An accepted word appears on flitOut the next cycle: type body, or tail when remaining == 1.
  - remaining decrements per accepted word.
  - On tail transfer, go to IDLE; req_ready=1 the cycle after the tail transfer.
- Throughput: one flit per cycle with networkReady=1 and data_valid=1. len=N gives N+1 flits back-to-back.
- networkReady low: flitOut is held and data_ready=0, so no word is lost or duplicated.
- data_valid low mid-packet: flitOut=0 (idle) until the next word arrives. The packet stays open; there is no timeout.
- req_valid during HEAD/PAYLOAD is ignored (req_ready=0).
- Reset mid-packet: flitOut=0 immediately; the partial packet is abandoned. The router side is reset with it.
- remaining uses an LEN_W-bit counter and never wraps; maximum len = 2^LEN_W-1.

Optional Feature:
- Macro NOC_INJ_STATS_EN.
- Defined:
  - Adds outputs stat_pkts[31:0] (tails sent), stat_flits[31:0] (all flits transferred) and stat_stall[31:0] (cycles with flit present and networkReady=0).
  - Counters saturate at all-ones and clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package noc_inj_pkg holds:
  - flit_type_t enum (IDLE/HEAD/BODY/TAIL)
  - head field offsets/widths
  - state_t enum (IDLE/HEAD/PAYLOAD)
  - function node_to_xy
- One sub-module, noc_inj_out_reg:
  - single-entry flit output register with load/transfer handshake
  - reused later by a host-side response path

Test Plan:
- Reset: assert rst mid-cycle -> flitOut=0, req_ready=0 asynchronously; deassert -> req_ready=1 next edge.
- dest=5, len=3, data A/B/C, networkReady=1 -> head (dx=2, dy=1, src=15, len=3), body A, body B, tail C on four consecutive cycles; req_ready=1 the cycle after C.
- Same packet, networkReady low for 2 cycles while body A is presented -> flitOut holds body A, data_ready=0, then B and tail C follow with no loss or duplicate.
- len=1, dest=0 -> head (dx=0, dy=0, len=1) then tail word; no body flit.
- dest=9 or len=0 -> one err_drop pulse, flitOut stays 0, req_ready stays 1.
- rst pulse after head transfer of a len=4 packet -> flitOut=0, busy=0; a new len=2 request afterwards emits a clean head/body/tail sequence; with NOC_INJ_STATS_EN, stat_pkts=1 and stat_flits=3.
